// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: passive HD44780 8-bit bus listener that keeps a 2x16 shadow character buffer.
module lcd_bus_receiver #(
  parameter int          EN_MIN_HIGH = 8,
  parameter logic [7:0]  CLEAR_CHAR  = 8'h20
) (
  input  logic       clock_50MHz,
  input  logic       RESET_n,
  input  logic [7:0] LCD_D,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [4:0] cursor_addr,
  output logic       display_on,
  output logic       busy,
  output logic       wr_strobe,
  output logic       overrun
);
  localparam int CW = $clog2(EN_MIN_HIGH + 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_n;
  logic [10:0] s1, s2;
  logic en_p, lat_rs, lat_rw;
  logic [7:0] lat_d;
  logic [CW-1:0] cnt;
  logic [6:0] ac, ac_n, ac_inc, ac_dec;
  logic id, id_n, disp_n, ovr_n, we, data_wr, commit;
  logic [4:0] clr_idx, wa;
  logic [7:0] wd;
  logic [7:0] mem [32];
  assign commit = en_p & ~s2[10] & (cnt == CW'(EN_MIN_HIGH)) & ~lat_rw;
  assign cursor_addr = {ac[6], ac[3:0]};
  assign busy = state == CLEAR;
  assign ac_inc = ac[3:0] == 4'hF ? {~ac[6], 6'h00} : ac + 7'd1;
  assign ac_dec = ac[3:0] == 4'h0 ? {~ac[6], 6'h0F} : ac - 7'd1;
  always_comb begin
    state_n = state;
    ac_n = ac;
    id_n = id;
    disp_n = display_on;
    ovr_n = overrun;
    we = 1'b0;
    data_wr = 1'b0;
    wa = clr_idx;
    wd = CLEAR_CHAR;
    if (state == CLEAR) begin
      we = 1'b1;
      ovr_n = overrun | commit;
      if (clr_idx == 5'd31) begin
        state_n = IDLE;
        ac_n = 7'h00;
        id_n = 1'b1;
      end
    end else if (commit) begin
      if (lat_rs) begin
        we = 1'b1;
        data_wr = 1'b1;
        wa = cursor_addr;
        wd = lat_d;
        ac_n = id ? ac_inc : ac_dec;
      end else if (lat_d[7]) ac_n = lat_d[5:4] == 2'b00 ? lat_d[6:0] : ac;
      else if (lat_d[6:4] != 3'd0) ac_n = ac;
      else if (lat_d[3]) disp_n = lat_d[2];
      else if (lat_d[2]) id_n = lat_d[1];
      else if (lat_d[1]) ac_n = 7'h00;
      else if (lat_d[0]) state_n = CLEAR;
    end
  end
  always_ff @(posedge clock_50MHz) begin
    if (!RESET_n) begin
      state <= CLEAR;
      s1 <= '0;
      s2 <= '0;
      en_p <= 1'b0;
      cnt <= '0;
      lat_d <= '0;
      lat_rs <= 1'b0;
      lat_rw <= 1'b0;
      ac <= 7'h00;
      id <= 1'b1;
      display_on <= 1'b0;
      overrun <= 1'b0;
      wr_strobe <= 1'b0;
      clr_idx <= '0;
      rd_data <= '0;
    end else begin
      state <= state_n;
      s1 <= {LCD_EN, LCD_RW, LCD_RS, LCD_D};
      s2 <= s1;
      en_p <= s2[10];
      cnt <= !s2[10] ? '0 : cnt == CW'(EN_MIN_HIGH) ? cnt : cnt + 1'b1;
      if (s2[10]) {lat_rw, lat_rs, lat_d} <= s2[9:0];
      ac <= ac_n;
      id <= id_n;
      display_on <= disp_n;
      overrun <= ovr_n;
      wr_strobe <= data_wr;
      clr_idx <= state == CLEAR ? clr_idx + 5'd1 : 5'd0;
      rd_data <= mem[rd_addr];
    end
  end
  always_ff @(posedge clock_50MHz)
    if (RESET_n && we) mem[wa] <= wd;
endmodule
